// File: rtl/aud_pkg.sv
// Shared audio definitions: word/slot geometry and the stereo frame type.
package aud_pkg;

    localparam int unsigned WORD_BITS  = 16;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;

    typedef struct packed {
        logic [WORD_BITS-1:0] left;
        logic [WORD_BITS-1:0] right;
    } aud_frame_t;

    // Slot positions 1..WORD_BITS carry sample bits; position 0 is the I2S one-bit delay.
    function automatic logic is_data_pos(input logic [4:0] pos);
        return (pos >= 5'd1) && (pos <= 5'(WORD_BITS));
    endfunction

endpackage

// File: rtl/aud_frame_fifo.sv
// Stereo frame FIFO, first-word-fall-through. Pushes while full and pops while
// empty are ignored; a simultaneous push and pop both take effect.
module aud_frame_fifo
    import aud_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  aud_frame_t             i_data,
    input  logic                   i_pop,
    output aud_frame_t             o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    aud_frame_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    // Qualify requests against occupancy before this cycle's update.
    always_comb begin
        push_ok = i_push && (count_q != FULL_CNT);
        pop_ok  = i_pop && (count_q != '0);
    end

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; entries are only read while valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: BCLK divider, 64-bit frame counter, per-channel
// shifters and word select, fed from a small stereo frame FIFO.
module i2s_master_tx
    import aud_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [WORD_BITS-1:0] i_left,
    input  logic [WORD_BITS-1:0] i_right,
    output logic                 o_ready,
    output logic                 o_bclk,
    output logic                 o_daclrck,
    output logic                 o_aud_dacdat,
    output logic                 o_underflow
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MAX_CNT = FIFO_DEPTH[CW-1:0];
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e               state_q;
    logic [7:0]           div_q;
    logic                 bclk_q;
    logic [5:0]           bit_q;
    logic                 lrck_q;
    logic                 dat_q;
    logic                 underflow_q;
    logic [WORD_BITS-1:0] left_sh_q;
    logic [WORD_BITS-1:0] right_sh_q;

    aud_frame_t           in_frame;
    aud_frame_t           fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_pop;

    logic                 div_tc;
    logic                 fall_tick;
    logic                 frame_start;
    logic                 boundary;
    logic [5:0]           next_bit;

    assign in_frame = {i_left, i_right};

    aud_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_valid),
        .i_data  (in_frame),
        .i_pop   (fifo_pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Timing strobes; a boundary is a frame start from idle or a 63->0 wrap that continues.
    always_comb begin
        div_tc      = (div_q == DIV_LAST);
        fall_tick   = (state_q == StRun) && div_tc && bclk_q;
        frame_start = (state_q == StIdle) && i_en;
        boundary    = frame_start || (fall_tick && (bit_q == LAST_BIT) && i_en);
        fifo_pop    = boundary && !fifo_empty;
        next_bit    = bit_q + 6'd1;
    end

    // Frame sequencer: divider, bit counter, shifters and all serial outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_q       <= '0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            underflow_q <= 1'b0;
            left_sh_q   <= '0;
            right_sh_q  <= '0;
        end else begin
            underflow_q <= boundary && fifo_empty;
            // An empty FIFO at a boundary sends a silent frame.
            if (boundary) begin
                left_sh_q  <= fifo_pop ? fifo_data.left : '0;
                right_sh_q <= fifo_pop ? fifo_data.right : '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (i_en) begin
                        state_q <= StRun;
                        div_q   <= '0;
                        bclk_q  <= 1'b0;
                        bit_q   <= '0;
                        lrck_q  <= 1'b0;
                        dat_q   <= 1'b0;
                    end
                end
                StRun: begin
                    if (div_tc) begin
                        div_q  <= '0;
                        bclk_q <= ~bclk_q;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                    if (fall_tick) begin
                        if (bit_q == LAST_BIT) begin
                            // Frame complete: idle here if disabled, else restart at bit 0.
                            bit_q  <= '0;
                            lrck_q <= 1'b0;
                            dat_q  <= 1'b0;
                            if (!i_en) state_q <= StIdle;
                        end else begin
                            bit_q  <= next_bit;
                            lrck_q <= next_bit[5];
                            if (!is_data_pos(next_bit[4:0])) begin
                                dat_q <= 1'b0;
                            end else if (!next_bit[5]) begin
                                dat_q     <= left_sh_q[WORD_BITS-1];
                                left_sh_q <= {left_sh_q[WORD_BITS-2:0], 1'b0};
                            end else begin
                                dat_q      <= right_sh_q[WORD_BITS-1];
                                right_sh_q <= {right_sh_q[WORD_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Occupancy can never exceed the FIFO depth.
    count_bound_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        fifo_count <= MAX_CNT);

    assign o_ready      = !fifo_full;
    assign o_bclk       = bclk_q;
    assign o_daclrck    = lrck_q;
    assign o_aud_dacdat = dat_q;
    assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: time-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed frame and timing expectations.
module tb_i2s_master_tx;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int          FRAME_CLK  = 128 * CLK_DIV;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en    = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_left  = '0;
    logic [15:0] i_right = '0;
    logic        o_ready;
    logic        o_bclk;
    logic        o_daclrck;
    logic        o_aud_dacdat;
    logic        o_underflow;

    i2s_master_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_valid      (i_valid),
        .i_left       (i_left),
        .i_right      (i_right),
        .o_ready      (o_ready),
        .o_bclk       (o_bclk),
        .o_daclrck    (o_daclrck),
        .o_aud_dacdat (o_aud_dacdat),
        .o_underflow  (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Waveform is a pure function of cycles since frame start (m_t) and the current frame.
    bit          m_run = 0;
    int          m_t   = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_cur = '0;
    bit          m_uf  = 0;
    bit          m_bnd, m_empty, m_canpush;

    initial begin
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) begin
                m_run = 0; m_t = 0; m_q.delete(); m_cur = '0; m_uf = 0;
            end else begin
                m_empty   = (m_q.size() == 0);
                m_canpush = (m_q.size() < FIFO_DEPTH);
                m_bnd = 0;
                m_uf  = 0;
                if (!m_run) begin
                    if (i_en) begin m_run = 1; m_t = 0; m_bnd = 1; end
                end else begin
                    m_t++;
                    if (m_t == FRAME_CLK) begin
                        m_t = 0;
                        if (i_en) m_bnd = 1;
                        else m_run = 0;
                    end
                end
                if (m_bnd) begin
                    if (m_empty) begin m_cur = '0; m_uf = 1; end
                    else m_cur = m_q.pop_front();
                end
                if (i_valid && m_canpush) m_q.push_back({i_left, i_right});
            end
        end
    end

    function automatic logic exp_bclk();
        return m_run && (((m_t / CLK_DIV) % 2) == 1);
    endfunction

    function automatic logic exp_lr();
        return m_run && ((m_t / (2 * CLK_DIV)) >= 32);
    endfunction

    function automatic logic exp_dat();
        int b = m_t / (2 * CLK_DIV);
        int pos = b % 32;
        logic [15:0] w = (b < 32) ? m_cur[31:16] : m_cur[15:0];
        if (!m_run || pos < 1 || pos > 16) return 1'b0;
        return w[16 - pos];
    endfunction

    // ---------------- monitor / compare ----------------
    int          cyc = 0;
    logic [63:0] win = '0;
    logic [63:0] lrw = '0;
    logic        prev_bclk = 1'b0;
    logic        prev_lr = 1'b0;
    int          last_rise = 0, bclk_per = 0;
    int          last_uf = 0, uf_per = 0;
    int          last_lr = 0, lr_hi = 0, lr_lo = 0;
    logic [31:0] cap[$];

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            cyc++;
            chk("bclk", o_bclk, exp_bclk());
            chk("daclrck", o_daclrck, exp_lr());
            chk("dacdat", o_aud_dacdat, exp_dat());
            chk("underflow", o_underflow, m_uf);
            chk("ready", o_ready, m_q.size() < FIFO_DEPTH);
            if (!i_rst_n) begin
                win = '0; lrw = '0; prev_bclk = 1'b0; prev_lr = 1'b0;
            end else begin
                // Capture a frame once 64 rising-edge samples show a full left+right word select.
                if (!prev_bclk && o_bclk) begin
                    win = {win[62:0], o_aud_dacdat};
                    lrw = {lrw[62:0], o_daclrck};
                    bclk_per = cyc - last_rise;
                    last_rise = cyc;
                    if (lrw == 64'h0000_0000_FFFF_FFFF) cap.push_back({win[62:47], win[30:15]});
                end
                prev_bclk = o_bclk;
                if (o_underflow) begin uf_per = cyc - last_uf; last_uf = cyc; end
                if (o_daclrck != prev_lr) begin
                    if (prev_lr) lr_hi = cyc - last_lr;
                    else lr_lo = cyc - last_lr;
                    last_lr = cyc;
                end
                prev_lr = o_daclrck;
            end
        end
    end

    function automatic logic [31:0] cap_at(input int i);
        if (i >= 0 && i < cap.size()) return cap[i];
        return 32'hDEAD_BEEF;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] l, input logic [15:0] r, input string nm);
        int n;
        n = 0;
        i_left = l; i_right = r; i_valid = 1'b1;
        while (!o_ready && n < 600) begin @(negedge i_clk); n++; end
        chk(nm, n < 600, 1);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_t(input int v, input string nm);
        int n;
        n = 0;
        while (!(m_run && m_t == v) && n < 600) begin @(negedge i_clk); n++; end
        chk(nm, n < 600, 1);
    endtask

    task automatic wait_cap(input int k, input int budget, input string nm);
        int n;
        n = 0;
        while (cap.size() < k && n < budget) begin @(negedge i_clk); n++; end
        chk(nm, n < budget, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int   k;
        int   n;
        logic acc;

        repeat (3) @(negedge i_clk);
        chk("rst_bclk", o_bclk, 0);
        chk("rst_lrck", o_daclrck, 0);
        chk("rst_dat", o_aud_dacdat, 0);
        chk("rst_uf", o_underflow, 0);
        chk("rst_ready", o_ready, 1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // One frame then enable: 0x8001 / 0x7FFE.
        send(16'h8001, 16'h7FFE, "send_first");
        chk("ready_one_entry", o_ready, 1);
        cap.delete();
        i_en = 1'b1;
        wait_cap(1, 600, "cap_first");
        chk("frame_8001_7ffe", cap_at(0), 32'h8001_7FFE);
        chk("bclk_period", bclk_per, 4);

        // Starved: periodic underflow, silent frames, square word select.
        repeat (3 * 256) @(negedge i_clk);
        chk("uf_period", uf_per, 256);
        chk("lrck_high_len", lr_hi, 128);
        chk("lrck_low_len", lr_lo, 128);
        chk("starved_frame", cap_at(cap.size() - 1), 0);

        // Back-to-back pushes into depth-2 FIFO; order preserved.
        wait_t(20, "wait_t20_a");
        cap.delete();
        send(16'h1234, 16'hABCD, "send_a");
        send(16'hFFFF, 16'h0001, "send_b");
        chk("ready_full", o_ready, 0);
        send(16'h8000, 16'h5A5A, "send_c");
        wait_cap(4, 1300, "cap_abc");
        chk("order_zero", cap_at(0), 0);
        chk("order_a", cap_at(1), 32'h1234_ABCD);
        chk("order_b", cap_at(2), 32'hFFFF_0001);
        chk("order_c", cap_at(3), 32'h8000_5A5A);

        // Push exactly on the boundary cycle with an empty FIFO.
        wait_t(FRAME_CLK - 1, "wait_pre_bnd");
        cap.delete();
        i_left = 16'h0F0F; i_right = 16'hF0F0; i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bnd_push_uf", o_underflow, 1);
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_cap(2, 600, "cap_bnd");
        chk("bnd_zero_frame", cap_at(0), 0);
        chk("bnd_next_frame", cap_at(1), 32'h0F0F_F0F0);

        // Drop enable at bit 40, idle, then re-enable.
        wait_t(20, "wait_t20_e");
        cap.delete();
        send(16'h00FF, 16'hFF00, "send_e");
        wait_t(0, "wait_bnd_e");
        wait_t(160, "wait_bit40");
        i_en = 1'b0;
        n = 0;
        while (m_run && n < 600) begin @(negedge i_clk); n++; end
        chk("idle_reached", n < 600, 1);
        chk("drop_zero_frame", cap_at(0), 0);
        chk("drop_e_frame", cap_at(1), 32'h00FF_FF00);
        acc = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            acc = acc | o_bclk | o_daclrck | o_aud_dacdat;
        end
        chk("idle_quiet", acc, 0);
        send(16'h6B6B, 16'h9494, "send_g");
        cap.delete();
        i_en = 1'b1;
        k = 0;
        do begin
            @(posedge i_clk);
            #1;
            k++;
        end while (!o_bclk && k < 20);
        chk("rise_delay", k - 1, 2);
        wait_cap(1, 600, "cap_g");
        chk("reenable_frame", cap_at(0), 32'h6B6B_9494);

        // Reset at bit 20 with two frames queued.
        wait_t(20, "wait_t20_h");
        send(16'hCAFE, 16'hBEEF, "send_h");
        send(16'h1357, 16'h2468, "send_j");
        wait_t(80, "wait_bit20");
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_bclk", o_bclk, 0);
        chk("mid_rst_lrck", o_daclrck, 0);
        chk("mid_rst_dat", o_aud_dacdat, 0);
        chk("mid_rst_uf", o_underflow, 0);
        chk("mid_rst_ready", o_ready, 1);
        cap.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (800) @(negedge i_clk);
        chk("post_rst_frames", cap.size() >= 2, 1);
        foreach (cap[i]) chk("post_rst_zero", cap[i], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_master_tx.md
I2S_MASTER_TX -- requirements
Module: i2s_master_tx

Interface
REQ-001 Parameter CLK_DIV, 2, number of i_clk cycles per BCLK half-period; legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, 2, number of stereo frames buffered; power of two, 2..16.
REQ-003 Port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_en  input  1  serial output enable; frames start only at frame boundaries.
REQ-006 Port i_valid  input  1  a stereo frame is offered on i_left/i_right.
REQ-007 Port i_left  input  16  left sample, two's complement.
REQ-008 Port i_right  input  16  right sample, two's complement.
REQ-009 Port o_ready  output  1  FIFO not full; a frame is accepted when i_valid && o_ready.
REQ-010 Port o_bclk  output  1  generated bit clock, registered.
REQ-011 Port o_daclrck  output  1  word select; 0 = left slot, 1 = right slot; registered.
REQ-012 Port o_aud_dacdat  output  1  serial data, MSB first, registered.
REQ-013 Port o_underflow  output  1  one-cycle pulse when a frame boundary finds the FIFO empty.

Function
REQ-014 The divider counts 0..CLK_DIV-1 while i_en=1; at terminal count o_bclk toggles.
REQ-015 Frame = 64 BCLK periods; a 6-bit bit counter advances on each BCLK falling-edge toggle.
REQ-016 o_daclrck = 0 for bit counts 0..31 and 1 for 32..63; it changes on BCLK falling edges only.
REQ-017 I2S timing: MSB appears at slot position 1, one BCLK after the o_daclrck edge; positions 1..16 carry bits 15..0; positions 0 and 17..31 drive 0.
REQ-018 o_aud_dacdat changes only on BCLK falling edges and is stable across each rising edge.
REQ-019 At each frame boundary (counter wrap 63->0, and the first cycle i_en is seen high), one frame is popped into the left/right shift registers.
REQ-020 Empty FIFO at a boundary: load 0x0000 into both channels and assert o_underflow for exactly one i_clk cycle.
REQ-021 Simultaneous push and pop: both take effect; pop evaluates occupancy before the push, so push-into-empty plus pop gives underflow and leaves one entry.
REQ-022 Push while full is ignored (o_ready=0); occupancy never exceeds FIFO_DEPTH, and pointers wrap modulo FIFO_DEPTH.
REQ-023 i_en falling: the current frame completes through bit count 63, then o_bclk, o_daclrck, and o_aud_dacdat idle at 0 with counters held at 0; the FIFO keeps accepting.
REQ-024 i_en rising while idle: the frame starts at once; the first o_bclk rising edge occurs CLK_DIV cycles later.
REQ-025 Latency: a frame pushed into an empty, enabled-but-idle FIFO is output at the next boundary, with MSB after 1.5 BCLK periods.

Reset
REQ-026 Reset asserted: o_bclk=0, o_daclrck=0, o_aud_dacdat=0, o_underflow=0, FIFO empty (o_ready=1), all counters 0.
REQ-027 Reset mid-frame aborts immediately and discards the FIFO contents; after release, operation resumes per REQ-024.

Structure
REQ-028 The shared package aud_pkg holds WORD_BITS=16, SLOT_BITS=32, and typedef aud_frame_t (left, right).
REQ-029 The FIFO is the sub-module aud_frame_fifo (push/pop/full/empty/count); the divider, bit counter, and shifter live in i2s_master_tx.

Verification
REQ-030 CLK_DIV=2, i_en=1, push L=0x8001 R=0x7FFE -> BCLK period 4 clk; frame 256 clk; left slot bits 1..16 = 1000000000000001; right = 0111111111111110.
REQ-031 No push, i_en=1 -> o_underflow pulses every 256 clk; o_aud_dacdat stays 0; o_daclrck is a 50% square wave of 256 clk period.
REQ-032 Push 3 frames back-to-back with FIFO_DEPTH=2 -> o_ready=0 after the 2nd push; the 3rd is accepted only after the next boundary pop; output order is preserved.
REQ-033 Push exactly at the boundary cycle with an empty FIFO -> underflow pulse plus zero frame; the pushed frame is output in the following frame.
REQ-034 i_en dropped at bit count 40 -> output continues to bit 63, then idles at 0; re-enable -> first BCLK rise 2 clk later, with the next FIFO frame.
REQ-035 i_rst_n pulsed low at bit count 20 -> all outputs 0 within the reset cycle, o_ready=1, and previously queued frames are never transmitted.
